// File: rtl/bike_pkg.sv
// Shared BIKE definitions: reader FSM states, a constant-safe clog2 and polynomial word counts.
package bike_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int WORD_BITS = 32;

  // Level-1 parameter set and a reduced-size set used for bring-up.
  localparam int R_BITS_L1   = 12323;
  localparam int R_WORDS_L1  = (R_BITS_L1 + WORD_BITS - 1) / WORD_BITS;
  localparam int R_BITS_TOY  = 523;
  localparam int R_WORDS_TOY = (R_BITS_TOY + WORD_BITS - 1) / WORD_BITS;

endpackage

// File: rtl/bike_fifo2.sv
// 2-entry first-word-fall-through FIFO; head visible the cycle after push.
// The caller guarantees it never pushes when full unless it pops in the same cycle.
module bike_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bike_bram_rev_reader.sv
// Streams a polynomial out of a 1-cycle-latency BRAM in descending, wrapping address order.
// First word one cycle after ram_en; reads are credit-limited to 2 outstanding words so ready may stall forever.
module bike_bram_rev_reader
  import bike_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int WORDS      = 17,
  parameter int START_ADDR = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int                CNT_W      = clog2(WORDS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(WORDS - 1);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  issued;
  logic              inflight;
  logic              inflight_last;
  logic              issue_last;
  logic [1:0]        occ;
  logic [DATA_W:0]   fifo_head;
  logic              bypass;
  logic              pop;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2:0]        owed;

  // A response arriving into an empty FIFO is presented straight from the BRAM.
  assign bypass    = inflight && (occ == 2'd0);
  assign out_valid = inflight || (occ != 2'd0);
  assign {out_last, out_data} = bypass ? {inflight_last, ram_dout} : fifo_head;
  assign pop       = out_valid && out_ready;
  assign fifo_push = inflight && !(bypass && out_ready);
  assign fifo_pop  = pop && !bypass;

  // Words already owed downstream: buffered plus the read in flight, less the one leaving now.
  assign owed       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue_last = (issued == LAST_ISSUE);
  assign ram_addr   = addr;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        ram_en = (owed < 3'd2);
        if (ram_en && issue_last) state_nxt = DRAIN;
      end
      DRAIN: if (pop && out_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      addr          <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= ram_en;
      if (ram_en) inflight_last <= issue_last;
      if (state == IDLE && start) begin
        addr   <= ADDR_W'(START_ADDR);
        issued <= '0;
      end else if (ram_en) begin
        addr   <= (addr == '0) ? LAST_ADDR : addr - 1'b1;
        issued <= issued + 1'b1;
      end
    end
  end

  bike_fifo2 #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (fifo_push),
    .push_dat ({inflight_last, ram_dout}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .occ      (occ)
  );

endmodule

// File: tb/tb_bike_bram_rev_reader.sv
// Bench for bike_bram_rev_reader: a word-order scoreboard checked every cycle, plus a second
// instance with START_ADDR = WORDS-1 for the no-wrap order.
module tb_bike_bram_rev_reader;
  import bike_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int WORDS  = R_WORDS_TOY;
  localparam int START  = 1;
  localparam int START2 = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start, start2;
  logic              out_ready, out_ready2;
  logic              busy, done, ram_en, out_valid, out_last;
  logic              busy2, done2, ram_en2, out_valid2, out_last2;
  logic [ADDR_W-1:0] ram_addr, ram_addr2;
  logic [DATA_W-1:0] ram_dout = '0, ram_dout2 = '0;
  logic [DATA_W-1:0] out_data, out_data2;

  bike_bram_rev_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .START_ADDR(START)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  bike_bram_rev_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .START_ADDR(START2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .busy(busy2), .done(done2),
    .ram_en(ram_en2), .ram_addr(ram_addr2), .ram_dout(ram_dout2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] mem [0:31];
  initial for (int a = 0; a < 32; a++) mem[a] = 32'h1000_0000 + a;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en)  ram_dout  <= mem[ram_addr];
    if (ram_en2) ram_dout2 <= mem[ram_addr2];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // k-th word of a stream comes from address START-k, taken modulo WORDS.
  function automatic int exp_addr(input int start_a, input int k);
    int a;
    a = (start_a - k) % WORDS;
    if (a < 0) a += WORDS;
    return a;
  endfunction

  int          busy_exp = 0, done_exp = 0, issued_n = 0, popped_n = 0;
  int          start_cyc = 0, first_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic        pop_now, stall_prev = 1'b0, stall_last = 1'b0;
  logic [31:0] stall_dat = '0;
  logic [31:0] got [0:WORDS-1];

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_data", out_data, 0);
      busy_exp = 0; done_exp = 0; issued_n = 0; popped_n = 0; stall_prev = 1'b0;
    end else begin
      pop_now = out_valid && out_ready;
      chk("busy", busy, busy_exp);
      chk("done", done, done_exp);
      if (busy_exp == 0) begin
        chk("idle_valid", out_valid, 0);
        chk("idle_ram_en", ram_en, 0);
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, stall_dat);
        chk("stall_last", out_last, stall_last);
      end
      if (ram_en) begin
        chk("ram_addr", ram_addr, exp_addr(START, issued_n));
        chk("credit", (issued_n - popped_n - (pop_now ? 1 : 0)) < 2, 1);
        chk("issue_count", issued_n < WORDS, 1);
        issued_n++;
      end
      if (pop_now) begin
        chk("pop_count", popped_n < WORDS, 1);
        if (popped_n < WORDS) begin
          chk("data", out_data, mem[exp_addr(START, popped_n)]);
          chk("last", out_last, popped_n == WORDS - 1);
          got[popped_n] = out_data;
        end
        if (popped_n == 0) first_cyc = cyc;
        popped_n++;
      end
      stall_prev = out_valid && !out_ready;
      stall_dat  = out_data;
      stall_last = out_last;
      if (done) done_cnt++;
      if (done_exp != 0) begin
        busy_exp = 0;
        done_cyc = cyc;
      end else if (start && busy_exp == 0) begin
        busy_exp = 1; issued_n = 0; popped_n = 0; start_cyc = cyc;
      end
      done_exp = (pop_now && popped_n == WORDS) ? 1 : 0;
    end
  end

  logic [31:0] q2_dat [$];
  logic        q2_last [$];
  int          done2_cnt = 0;

  always @(negedge clk) begin
    if (resetn && out_valid2 && out_ready2) begin
      q2_dat.push_back(out_data2);
      q2_last.push_back(out_last2);
    end
    if (resetn && done2) done2_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      1:       return (k % 4 == 0) || (k % 4 == 3);
      2:       return k > 10;
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready high; 1: ready 1,0,0,1 repeating; 2: ready low 10 cycles; 3: start re-pulsed mid-stream
  task automatic stream(input int mode, input string name);
    int d0, k;
    d0 = done_cnt;
    start = 1'b1;
    out_ready = ready_for(mode, 0);
    step(1);
    start = 1'b0;
    k = 1;
    while (done_cnt == d0 && k < 400) begin
      out_ready = ready_for(mode, k);
      start = (mode == 3) && (k == 5 || k == 12);
      if (mode == 2 && k == 11) begin
        chk({name, "_issues_while_stalled"}, issued_n, 2);
        chk({name, "_pops_while_stalled"}, popped_n, 0);
      end
      step(1);
      k++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    chk({name, "_words"}, popped_n, WORDS);
  endtask

  initial begin
    int d0;
    resetn = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    step(3);
    resetn = 1'b1;
    step(2);

    stream(0, "basic");
    chk("basic_done_cycle", done_cyc - start_cyc, 19);
    chk("basic_first_valid", first_cyc - start_cyc, 2);
    chk("basic_w0", got[0], 32'h1000_0001);
    chk("basic_w1", got[1], 32'h1000_0000);
    chk("basic_w2_wrap", got[2], 32'h1000_0010);
    chk("basic_w16", got[16], 32'h1000_0002);
    step(2);

    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    step(25);
    chk("nowrap_count", q2_dat.size(), 17);
    chk("nowrap_done_pulses", done2_cnt, 1);
    for (int i = 0; i < q2_dat.size() && i < 17; i++) begin
      chk("nowrap_data", q2_dat[i], 32'h1000_0010 - i);
      chk("nowrap_last", q2_last[i], i == 16);
    end

    stream(1, "toggle_ready");
    step(1);
    stream(2, "ready_low10");
    step(1);
    stream(3, "restart_ignored");
    stream(0, "back_to_back");
    step(2);

    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 40 && popped_n < 8; k++) step(1);
    chk("pre_reset_progress", popped_n >= 8, 1);
    d0 = done_cnt;
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    step(4);
    chk("reset_no_done", done_cnt, d0);
    stream(0, "post_reset");
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
